pwm_deadtime_ctrl: RTL and testbench

PWM_DEADTIME_CTRL -- requirements
Module: pwm_deadtime_ctrl

---
 rtl/pwm_deadtime_ctrl_pkg.sv | 15 +
 rtl/pwm_deadtime_ctrl_dt_leg.sv | 105 ++++++++++
 rtl/pwm_deadtime_ctrl.sv | 88 ++++++++
 tb/tb_pwm_deadtime_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_deadtime_ctrl_pkg.sv
// Shared types and defaults for the three-leg PWM dead-time controller.
package pwm_deadtime_ctrl_pkg;

    localparam int DT_W         = 16;
    localparam int DEAD_DEFAULT = 500;

    typedef enum logic [2:0] {
        LEG_IDLE,
        LEG_DT_HI,
        LEG_ON_HI,
        LEG_DT_LO,
        LEG_ON_LO
    } leg_state_t;

endpackage

// File: rtl/pwm_deadtime_ctrl_dt_leg.sv
// Single half-bridge leg: break-before-make sequencing with a per-leg dead-time counter.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   LEG_IDLE  | both gates off, waiting for run permission
//   LEG_DT_HI | both gates off, counting dead time before high side
//   LEG_ON_HI | high-side gate on
//   LEG_DT_LO | both gates off, counting dead time before low side
//   LEG_ON_LO | low-side gate on
module dt_leg
    import pwm_deadtime_ctrl_pkg::*;
#(
    parameter int DT_W = pwm_deadtime_ctrl_pkg::DT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            force_off,
    input  logic            pwm_bit,
    input  logic [DT_W-1:0] dead,
    output logic            gate_hi,
    output logic            gate_lo,
    output logic            in_dt
);

    leg_state_t      state;
    logic [DT_W-1:0] cnt;
    logic            done;

    // >= rather than == keeps the leg from stalling if dead ever shrinks mid-count
    assign done = (cnt >= (dead - DT_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LEG_IDLE;
            cnt     <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            in_dt   <= 1'b0;
        end else if (force_off) begin
            state   <= LEG_IDLE;
            cnt     <= '0;
            gate_hi <= 1'b0;
            gate_lo <= 1'b0;
            in_dt   <= 1'b0;
        end else begin
            case (state)
                LEG_IDLE: begin
                    state <= pwm_bit ? LEG_DT_HI : LEG_DT_LO;
                    cnt   <= '0;
                    in_dt <= 1'b1;
                end
                LEG_DT_HI: begin
                    if (!pwm_bit) begin
                        state <= LEG_DT_LO;
                        cnt   <= '0;
                    end else if (done) begin
                        state   <= LEG_ON_HI;
                        gate_hi <= 1'b1;
                        in_dt   <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + DT_W'(1);
                    end
                end
                LEG_ON_HI: begin
                    if (!pwm_bit) begin
                        state   <= LEG_DT_LO;
                        gate_hi <= 1'b0;
                        in_dt   <= 1'b1;
                        cnt     <= '0;
                    end
                end
                LEG_DT_LO: begin
                    if (pwm_bit) begin
                        state <= LEG_DT_HI;
                        cnt   <= '0;
                    end else if (done) begin
                        state   <= LEG_ON_LO;
                        gate_lo <= 1'b1;
                        in_dt   <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + DT_W'(1);
                    end
                end
                LEG_ON_LO: begin
                    if (pwm_bit) begin
                        state   <= LEG_DT_HI;
                        gate_lo <= 1'b0;
                        in_dt   <= 1'b1;
                        cnt     <= '0;
                    end
                end
                default: begin
                    state   <= LEG_IDLE;
                    cnt     <= '0;
                    gate_hi <= 1'b0;
                    gate_lo <= 1'b0;
                    in_dt   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_deadtime_ctrl.sv
// Three-leg PWM gate driver with programmable dead time, fault latch and config guard.
module pwm_deadtime_ctrl
    import pwm_deadtime_ctrl_pkg::*;
#(
    parameter int DT_W         = pwm_deadtime_ctrl_pkg::DT_W,
    parameter int DEAD_DEFAULT = pwm_deadtime_ctrl_pkg::DEAD_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [2:0]      pwm,
    input  logic [DT_W-1:0] dead_clk,
    input  logic            cfg_load,
    input  logic            fault_n,
    input  logic            fault_clr,
    output logic [2:0]      gate_hi,
    output logic [2:0]      gate_lo,
    output logic            fault_lat,
    output logic            busy,
    output logic            cfg_err
);

    logic            fault_s1;
    logic            fault_s2;
    logic            force_off;
    logic [DT_W-1:0] dead_reg;
    logic [2:0]      leg_dt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_s1 <= 1'b1;
            fault_s2 <= 1'b1;
        end else begin
            fault_s1 <= fault_n;
            fault_s2 <= fault_s1;
        end
    end

    // A still-active fault wins over a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_lat <= 1'b0;
        end else if (!fault_s2) begin
            fault_lat <= 1'b1;
        end else if (fault_clr) begin
            fault_lat <= 1'b0;
        end
    end

    // Dead time may only change while the bridge is parked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_reg <= DT_W'(DEAD_DEFAULT);
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_load && enable;
            if (cfg_load && !enable) begin
                dead_reg <= (dead_clk == '0) ? DT_W'(1) : dead_clk;
            end
        end
    end

    assign force_off = !enable || fault_lat || !fault_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else begin
            busy <= |leg_dt;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_leg
        dt_leg #(
            .DT_W (DT_W)
        ) u_leg (
            .clk       (clk),
            .rst_n     (rst_n),
            .force_off (force_off),
            .pwm_bit   (pwm[i]),
            .dead      (dead_reg),
            .gate_hi   (gate_hi[i]),
            .gate_lo   (gate_lo[i]),
            .in_dt     (leg_dt[i])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime_ctrl.sv
// Directed plus randomized bench for pwm_deadtime_ctrl against a run-length reference model.
module tb_pwm_deadtime_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [2:0]  pwm;
    logic [15:0] dead_clk;
    logic        cfg_load;
    logic        fault_n;
    logic        fault_clr;
    logic [2:0]  gate_hi;
    logic [2:0]  gate_lo;
    logic        fault_lat;
    logic        busy;
    logic        cfg_err;

    pwm_deadtime_ctrl #(.DT_W(16), .DEAD_DEFAULT(500)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .pwm       (pwm),
        .dead_clk  (dead_clk),
        .cfg_load  (cfg_load),
        .fault_n   (fault_n),
        .fault_clr (fault_clr),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .fault_lat (fault_lat),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference: a gate is on once its side has been commanded, with the
    // bridge permitted to run, for more than dead_m consecutive edges.
    int       run_hi [3];
    int       run_lo [3];
    int       off_cnt[3];
    logic [2:0] prev_on;
    logic [2:0] gh_m, gl_m, dt_m;
    logic     busy_m, flat_m, fs1_m, fs2_m, cerr_m;
    int       dead_m;

    int t_rise, n_busy, hi_seen, t_off;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            run_hi[i]  = 0;
            run_lo[i]  = 0;
            off_cnt[i] = 0;
        end
        prev_on = '0;
        gh_m = '0; gl_m = '0; dt_m = '0;
        busy_m = 1'b0; flat_m = 1'b0; cerr_m = 1'b0;
        fs1_m = 1'b1; fs2_m = 1'b1;
        dead_m = 500;
    endfunction

    function automatic void model_edge();
        bit act;
        act = enable && !flat_m && fs2_m;
        busy_m = |dt_m;
        for (int i = 0; i < 3; i++) begin
            if (!act) begin
                run_hi[i] = 0; run_lo[i] = 0;
            end else if (pwm[i]) begin
                run_hi[i]++; run_lo[i] = 0;
            end else begin
                run_lo[i]++; run_hi[i] = 0;
            end
            gh_m[i] = (run_hi[i] > dead_m);
            gl_m[i] = (run_lo[i] > dead_m);
            dt_m[i] = act && !gh_m[i] && !gl_m[i];
        end
        cerr_m = cfg_load && enable;
        if (cfg_load && !enable) dead_m = (dead_clk == 16'd0) ? 1 : int'(dead_clk);
        if (!fs2_m) flat_m = 1'b1;
        else if (fault_clr) flat_m = 1'b0;
        fs2_m = fs1_m;
        fs1_m = fault_n;
    endfunction

    task automatic check_outputs();
        logic on;
        chk("gate_hi", 32'(gate_hi), 32'(gh_m));
        chk("gate_lo", 32'(gate_lo), 32'(gl_m));
        chk("fault_lat", 32'(fault_lat), 32'(flat_m));
        chk("busy", 32'(busy), 32'(busy_m));
        chk("cfg_err", 32'(cfg_err), 32'(cerr_m));
        chk("overlap", 32'(gate_hi & gate_lo), 32'd0);
        for (int i = 0; i < 3; i++) begin
            on = gate_hi[i] | gate_lo[i];
            if (on && !prev_on[i]) chk("dead_gap", 32'(off_cnt[i] >= dead_m), 32'd1);
            if (rst_n) off_cnt[i] = on ? 0 : off_cnt[i] + 1;
            prev_on[i] = on;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        cyc++;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; pwm = 3'b000; dead_clk = '0;
        cfg_load = 1'b0; fault_n = 1'b1; fault_clr = 1'b0;
        model_reset();
        #3;
        check_outputs();
        repeat (3) step();
        rst_n = 1'b1;

        // power-up dead time with enable already high
        t_rise = -1;
        for (int k = 1; k <= 600; k++) begin
            step();
            if (t_rise < 0 && gate_lo === 3'b111) t_rise = k;
        end
        chk("lo_after_reset", 32'(t_rise), 32'd501);

        // dead time 10, leg a low -> high
        enable = 1'b0; step();
        cfg_load = 1'b1; dead_clk = 16'd10; step();
        cfg_load = 1'b0; enable = 1'b1; pwm = 3'b000;
        repeat (15) step();
        pwm = 3'b001; step();
        chk("lo_drop_at_edge", 32'(gate_lo[0]), 32'd0);
        n_busy = busy ? 1 : 0;
        t_rise = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (busy) n_busy++;
            if (t_rise < 0 && gate_hi[0]) t_rise = k;
        end
        chk("hi_rise_gap", 32'(t_rise), 32'd10);
        chk("busy_cycles", 32'(n_busy), 32'd10);

        // short high pulse swallowed inside dead time
        pwm = 3'b000; repeat (15) step();
        pwm = 3'b001; hi_seen = 0;
        repeat (4) begin step(); if (gate_hi[0]) hi_seen = 1; end
        pwm = 3'b000; t_rise = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (gate_hi[0]) hi_seen = 1;
            if (t_rise < 0 && gate_lo[0]) t_rise = k;
        end
        chk("no_hi_pulse", 32'(hi_seen), 32'd0);
        chk("lo_after_reversal", 32'(t_rise), 32'd11);

        // fault during leg b dead time
        pwm = 3'b010; step();
        fault_n = 1'b0; t_off = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (t_off < 0 && gate_hi === 3'b000 && gate_lo === 3'b000) t_off = k;
        end
        chk("fault_off_edges", 32'(t_off), 32'd3);
        chk("fault_latched", 32'(fault_lat), 32'd1);
        fault_clr = 1'b1; step(); fault_clr = 1'b0; step();
        chk("clr_while_low", 32'(fault_lat), 32'd1);
        fault_n = 1'b1; repeat (3) step();
        fault_clr = 1'b1; step(); fault_clr = 1'b0;
        chk("clr_after_release", 32'(fault_lat), 32'd0);
        step(); step();
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_gates_off", 32'(gate_hi | gate_lo), 32'd0);
        repeat (12) step();
        chk("restart_hi", 32'(gate_hi), 32'd2);
        chk("restart_lo", 32'(gate_lo), 32'd5);

        // zero dead time clamps to one; load while running rejected
        enable = 1'b0; pwm = 3'b000; step();
        cfg_load = 1'b1; dead_clk = 16'd0; step();
        cfg_load = 1'b0; enable = 1'b1; step();
        chk("dt1_first_edge", 32'(gate_lo), 32'd0);
        step();
        chk("dt1_lo_on", 32'(gate_lo), 32'd7);
        cfg_load = 1'b1; dead_clk = 16'd7; step();
        cfg_load = 1'b0;
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        step();
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        pwm = 3'b111; step(); step();
        chk("dead_unchanged", 32'(gate_hi), 32'd7);

        // randomized traffic
        for (int n = 0; n < 30000; n++) begin
            if (n == 15000) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_outputs();
                step(); step();
                rst_n = 1'b1;
            end
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 15) == 0) pwm[i] = ~pwm[i];
            if (enable) enable = ($urandom_range(0, 399) != 0);
            else        enable = ($urandom_range(0, 7) == 0);
            cfg_load = enable ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0);
            dead_clk = 16'($urandom_range(0, 6));
            if (fault_n) fault_n = ($urandom_range(0, 1499) != 0);
            else         fault_n = ($urandom_range(0, 9) == 0);
            fault_clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
